// File: rtl/bus_drvr_fifo_endpoint_if.sv
// bus_drvr_fifo_endpoint_if: host and arbiter handshake signals of one driver endpoint
//   slave  modport: the endpoint (receives strobes and data, drives heads, flags and counts)
//   master modport: host and arbiter side
//   tx_push/tx_data/tx_full/tx_count/tx_ovf    host side of the TX FIFO
//   pndng/pop/D_pop                            arbiter drain of the TX FIFO
//   push/D_push                                arbiter delivery into the RX FIFO
//   rx_pop/rx_data/rx_pndng/rx_count/rx_ovf    host side of the RX FIFO
//   rx_drop_cnt                                bus pushes rejected by the id filter
interface bus_drvr_fifo_endpoint_if #(
    parameter int bits  = 256,
    parameter int depth = 8
);
    localparam int cw = $clog2(depth) + 1;
    logic            tx_push;
    logic [bits-1:0] tx_data;
    logic            tx_full;
    logic [cw-1:0]   tx_count;
    logic            pndng;
    logic            pop;
    logic [bits-1:0] D_pop;
    logic            push;
    logic [bits-1:0] D_push;
    logic            rx_pop;
    logic [bits-1:0] rx_data;
    logic            rx_pndng;
    logic [cw-1:0]   rx_count;
    logic            tx_ovf;
    logic            rx_ovf;
    logic [15:0]     rx_drop_cnt;
    modport slave (
        input  tx_push, tx_data, pop, push, D_push, rx_pop,
        output tx_full, tx_count, pndng, D_pop, rx_data, rx_pndng, rx_count, tx_ovf, rx_ovf, rx_drop_cnt
    );
    modport master (
        output tx_push, tx_data, pop, push, D_push, rx_pop,
        input  tx_full, tx_count, pndng, D_pop, rx_data, rx_pndng, rx_count, tx_ovf, rx_ovf, rx_drop_cnt
    );
endinterface

// File: rtl/bus_drvr_fifo_endpoint.sv
// bus_drvr_fifo_endpoint: driver-side bus endpoint with a host->bus TX FIFO and an id-filtered bus->host RX FIFO
//   clk    in  single clock, posedge
//   reset  in  synchronous active-high reset, clears both FIFOs, flags and the drop counter
//   bus    slave modport of bus_drvr_fifo_endpoint_if (TX/RX handshakes, heads, counts, overflow flags)
module bus_drvr_fifo_endpoint #(
    parameter int          bits      = 256,
    parameter int          depth     = 8,
    parameter logic [7:0]  id        = 8'd0,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input logic clk,
    input logic reset,
    bus_drvr_fifo_endpoint_if.slave bus
);
    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;
    // Pointers carry one extra wrap bit so wr-rd gives the occupancy directly
    logic [bits-1:0] tx_mem_q [depth];
    logic [cw-1:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, tx_cnt;
    logic            tx_ovf_q, tx_ovf_d, tx_empty, tx_full, tx_do_push, tx_do_pop;
    logic [bits-1:0] rx_mem_q [depth];
    logic [cw-1:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, rx_cnt;
    logic            rx_ovf_q, rx_ovf_d, rx_empty, rx_full, rx_do_push, rx_do_pop, rx_accept;
    logic [15:0]     drop_q, drop_d;
    always_comb begin
        tx_cnt     = tx_wr_q - tx_rd_q;
        tx_empty   = tx_cnt == '0;
        tx_full    = tx_cnt == cw'(depth);
        tx_do_pop  = bus.pop && !tx_empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
        tx_do_push = bus.tx_push && (!tx_full || tx_do_pop);
        tx_wr_d    = tx_do_push ? tx_wr_q + cw'(1) : tx_wr_q;
        tx_rd_d    = tx_do_pop ? tx_rd_q + cw'(1) : tx_rd_q;
        tx_ovf_d   = tx_ovf_q || (bus.tx_push && tx_full && !bus.pop);
    end
    always_comb begin
        rx_cnt     = rx_wr_q - rx_rd_q;
        rx_empty   = rx_cnt == '0;
        rx_full    = rx_cnt == cw'(depth);
        rx_accept  = bus.D_push[bits-1 -: 8] == id || bus.D_push[bits-1 -: 8] == broadcast;
        rx_do_pop  = bus.rx_pop && !rx_empty;
        rx_do_push = bus.push && rx_accept && (!rx_full || rx_do_pop);
        rx_wr_d    = rx_do_push ? rx_wr_q + cw'(1) : rx_wr_q;
        rx_rd_d    = rx_do_pop ? rx_rd_q + cw'(1) : rx_rd_q;
        // Only packets that pass the filter can overflow the RX FIFO
        rx_ovf_d   = rx_ovf_q || (bus.push && rx_accept && rx_full && !bus.rx_pop);
        drop_d     = (bus.push && !rx_accept && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_ovf_q <= 1'b0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_ovf_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_ovf_q <= tx_ovf_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_ovf_q <= rx_ovf_d;
            drop_q   <= drop_d;
        end
    end
    // Storage needs no reset: heads are masked to zero whenever a FIFO is empty
    always_ff @(posedge clk) begin
        if (!reset && tx_do_push) tx_mem_q[tx_wr_q[aw-1:0]] <= bus.tx_data;
        if (!reset && rx_do_push) rx_mem_q[rx_wr_q[aw-1:0]] <= bus.D_push;
    end
    assign bus.pndng       = !tx_empty;
    assign bus.tx_full     = tx_full;
    assign bus.tx_count    = tx_cnt;
    assign bus.D_pop       = tx_empty ? '0 : tx_mem_q[tx_rd_q[aw-1:0]];
    assign bus.tx_ovf      = tx_ovf_q;
    assign bus.rx_pndng    = !rx_empty;
    assign bus.rx_count    = rx_cnt;
    assign bus.rx_data     = rx_empty ? '0 : rx_mem_q[rx_rd_q[aw-1:0]];
    assign bus.rx_ovf      = rx_ovf_q;
    assign bus.rx_drop_cnt = drop_q;
endmodule

// File: tb/tb_bus_drvr_fifo_endpoint.sv
// tb_bus_drvr_fifo_endpoint: directed vector table plus hand sequences for the driver endpoint
module tb_bus_drvr_fifo_endpoint;
    localparam int BITS = 32, DEPTH = 8;
    logic clk = 1'b0, reset = 1'b0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    bus_drvr_fifo_endpoint_if #(.bits(BITS), .depth(DEPTH)) bus ();
    bus_drvr_fifo_endpoint #(.bits(BITS), .depth(DEPTH), .id(8'd3), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    typedef struct {
        logic rst; logic tx_push; logic [31:0] tx_data; logic pop; logic push; logic [31:0] d_push; logic rx_pop;
        logic pndng; logic [31:0] d_pop; logic [3:0] tx_count; logic tx_ovf;
        logic rx_pndng; logic [31:0] rx_data; logic [3:0] rx_count; logic rx_ovf; logic [15:0] drop;
    } vec_t;
    function automatic logic [91:0] outs();
        return {bus.pndng, bus.D_pop, bus.tx_count, bus.tx_ovf, bus.rx_pndng, bus.rx_data, bus.rx_count, bus.rx_ovf, bus.rx_drop_cnt};
    endfunction
    task automatic drive(input logic r, input logic tp, input logic [31:0] td, input logic p,
                         input logic ps, input logic [31:0] dp, input logic rp);
        @(negedge clk);
        reset = r; bus.tx_push = tp; bus.tx_data = td; bus.pop = p;
        bus.push = ps; bus.D_push = dp; bus.rx_pop = rp;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    localparam logic [31:0] A = 32'hA0000001, B = 32'hA0000002, C = 32'hA0000003, D = 32'hD0000004;
    localparam logic [31:0] P1 = 32'h03000001, P2 = 32'hFF000002, P3 = 32'h05000003, P4 = 32'h03000004;
    vec_t v [16];
    initial begin
        logic [91:0] exp_o;
        v[0]  = '{1, 1, A, 1, 1, P1, 1,  0, 0, 0, 0,  0, 0, 0, 0, 0};
        v[1]  = '{0, 1, A, 0, 0, 0, 0,   1, A, 1, 0,  0, 0, 0, 0, 0};
        v[2]  = '{0, 1, B, 0, 0, 0, 0,   1, A, 2, 0,  0, 0, 0, 0, 0};
        v[3]  = '{0, 1, C, 0, 0, 0, 0,   1, A, 3, 0,  0, 0, 0, 0, 0};
        v[4]  = '{0, 0, 0, 1, 0, 0, 0,   1, B, 2, 0,  0, 0, 0, 0, 0};
        v[5]  = '{0, 0, 0, 1, 0, 0, 0,   1, C, 1, 0,  0, 0, 0, 0, 0};
        v[6]  = '{0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0,  0, 0, 0, 0, 0};
        v[7]  = '{0, 0, 0, 0, 1, P1, 0,  0, 0, 0, 0,  1, P1, 1, 0, 0};
        v[8]  = '{0, 0, 0, 0, 1, P2, 0,  0, 0, 0, 0,  1, P1, 2, 0, 0};
        v[9]  = '{0, 0, 0, 0, 1, P3, 0,  0, 0, 0, 0,  1, P1, 2, 0, 1};
        v[10] = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0,  1, P2, 1, 0, 1};
        v[11] = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0,  0, 0, 0, 0, 1};
        v[12] = '{0, 0, 0, 1, 0, 0, 1,   0, 0, 0, 0,  0, 0, 0, 0, 1};
        v[13] = '{0, 1, D, 1, 1, P4, 1,  1, D, 1, 0,  1, P4, 1, 0, 1};
        v[14] = '{0, 0, 0, 1, 0, 0, 1,   0, 0, 0, 0,  0, 0, 0, 0, 1};
        v[15] = '{0, 0, 0, 0, 1, P3, 1,  0, 0, 0, 0,  0, 0, 0, 0, 2};
        for (int i = 0; i < 16; i++) begin
            drive(v[i].rst, v[i].tx_push, v[i].tx_data, v[i].pop, v[i].push, v[i].d_push, v[i].rx_pop);
            exp_o = {v[i].pndng, v[i].d_pop, v[i].tx_count, v[i].tx_ovf, v[i].rx_pndng, v[i].rx_data,
                     v[i].rx_count, v[i].rx_ovf, v[i].drop};
            checks++;
            if (outs() !== exp_o) begin
                errors++;
                $display("FAIL vec%0d: got %h expected %h", i, outs(), exp_o);
            end
        end
        // TX overflow and full push+pop
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 32'h100 + i, 0, 0, 0, 0);
        chk("tx_fill_count", 64'(bus.tx_count), 8);
        chk("tx_fill_full", 64'(bus.tx_full), 1);
        chk("tx_fill_ovf", 64'(bus.tx_ovf), 0);
        drive(0, 1, 32'hDEAD, 0, 0, 0, 0);
        chk("tx_ovf_set", 64'(bus.tx_ovf), 1);
        chk("tx_ovf_count", 64'(bus.tx_count), 8);
        chk("tx_ovf_head", 64'(bus.D_pop), 32'h100);
        drive(0, 1, 32'hBEEF, 1, 0, 0, 0);
        chk("tx_full_pp_count", 64'(bus.tx_count), 8);
        chk("tx_full_pp_head", 64'(bus.D_pop), 32'h101);
        chk("tx_full_pp_ovf", 64'(bus.tx_ovf), 1);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            chk($sformatf("tx_drain_head%0d", i), 64'(bus.D_pop), i < 6 ? 64'(32'h102 + i) : 64'(32'hBEEF));
            chk($sformatf("tx_drain_count%0d", i), 64'(bus.tx_count), 64'(7 - i));
        end
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("tx_drained_pndng", 64'(bus.pndng), 0);
        chk("tx_drained_head", 64'(bus.D_pop), 0);
        // RX overflow versus filter rejection
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, 32'h03000010 + i, 0);
        chk("rx_fill_count", 64'(bus.rx_count), 8);
        chk("rx_fill_ovf", 64'(bus.rx_ovf), 0);
        drive(0, 0, 0, 0, 1, 32'h03000099, 0);
        chk("rx_ovf_set", 64'(bus.rx_ovf), 1);
        chk("rx_ovf_count", 64'(bus.rx_count), 8);
        chk("rx_ovf_head", 64'(bus.rx_data), 32'h03000010);
        drive(0, 0, 0, 0, 1, 32'h07000001, 0);
        chk("rx_rej_drop", 64'(bus.rx_drop_cnt), 1);
        chk("rx_rej_ovf", 64'(bus.rx_ovf), 1);
        chk("rx_rej_count", 64'(bus.rx_count), 8);
        drive(0, 0, 0, 0, 1, 32'h03000AAA, 1);
        chk("rx_full_pp_count", 64'(bus.rx_count), 8);
        chk("rx_full_pp_head", 64'(bus.rx_data), 32'h03000011);
        // Reset mid-traffic with every strobe active
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 32'h200 + i, 0, 1, 32'h03000200 + i, 0);
        chk("half_tx_count", 64'(bus.tx_count), 4);
        chk("half_rx_count", 64'(bus.rx_count), 4);
        drive(0, 1, 32'h300, 0, 1, 32'h09000000, 0);
        chk("pre_reset_drop", 64'(bus.rx_drop_cnt), 1);
        drive(1, 1, 32'h55, 1, 1, 32'h03000055, 1);
        chk("reset_outs_lo", outs()[63:0], 0);
        chk("reset_outs_hi", 64'(outs()[91:64]), 0);
        chk("reset_tx_full", 64'(bus.tx_full), 0);
        drive(0, 1, 32'hE0E0, 0, 1, 32'h03000E0E, 0);
        chk("resume_tx_head", 64'(bus.D_pop), 32'hE0E0);
        chk("resume_tx_count", 64'(bus.tx_count), 1);
        chk("resume_rx_head", 64'(bus.rx_data), 32'h03000E0E);
        chk("resume_rx_count", 64'(bus.rx_count), 1);
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("resume_empty", 64'({bus.pndng, bus.rx_pndng}), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
